game_flow_ctrl: RTL

GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

---
 rtl/game_flow_ctrl.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// Game flow controller: synchronizes and debounces the five push-buttons,
// turns start/pause and quit presses into single-cycle pulses, runs the
// START/PLAY/PAUSE/OVER state machine and tracks the best score since reset.
module game_flow_ctrl #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int GAMEOVER_CYCLES = 75000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  buttons_raw,
    input  logic [2:0]  game_status,
    input  logic [13:0] score,
    output logic [2:0]  game_state,
    output logic [13:0] high_score,
    output logic [4:0]  buttons_play,
    output logic        new_record
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TW = $clog2(GAMEOVER_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(GAMEOVER_CYCLES - 1);
    // Shoot, right and left pass through during play; start/pause and quit never do.
    localparam logic [4:0] PLAY_MASK = 5'b10101;

    typedef enum logic [2:0] {
        ST_START = 3'b000,
        ST_PLAY  = 3'b001,
        ST_PAUSE = 3'b010,
        ST_OVER  = 3'b011
    } state_t;

    logic [4:0]    sync1_reg;
    logic [4:0]    sync2_reg;
    logic [4:0]    deb_level;
    logic [4:0]    deb_dly_reg;
    logic [4:0]    armed_reg;
    logic [4:0]    press_reg;
    logic [1:0]    settle_reg;
    logic [TW-1:0] timer_reg;
    state_t        state_reg;

    // Two-flop synchronizer on every raw button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= buttons_raw;
            sync2_reg <= sync1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_deb
            logic [CW-1:0] cnt_reg;
            logic          level_reg;

            // Count consecutive samples that disagree with the accepted level; flip once enough agree.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (sync2_reg[gi] == level_reg) begin
                    cnt_reg <= '0;
                end else if (cnt_reg == CNT_LAST) begin
                    level_reg <= ~level_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign deb_level[gi] = level_reg;
        end
    endgenerate

    // Edge-detect debounced rises into one-cycle presses. A button only becomes
    // armed after it has been seen released once the synchronizer holds real
    // samples, so a button held through reset release never yields a press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_reg  <= '0;
            armed_reg   <= '0;
            deb_dly_reg <= '0;
            press_reg   <= '0;
        end else begin
            if (settle_reg != 2'd2) begin
                settle_reg <= settle_reg + 1'b1;
            end else begin
                armed_reg <= armed_reg | ~sync2_reg;
            end
            deb_dly_reg <= deb_level;
            press_reg   <= deb_level & ~deb_dly_reg & armed_reg;
        end
    end

    // Game state machine with registered outputs, OVER hold timer and best-score tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_START;
            timer_reg    <= '0;
            high_score   <= '0;
            new_record   <= 1'b0;
            buttons_play <= '0;
        end else begin
            buttons_play <= '0;
            case (state_reg)
                ST_START: begin
                    if (press_reg[3]) begin
                        state_reg    <= ST_PLAY;
                        buttons_play <= deb_level & PLAY_MASK;
                    end
                end
                ST_PLAY: begin
                    if (game_status != 3'b000) begin
                        state_reg <= ST_OVER;
                        timer_reg <= '0;
                    end else if (press_reg[3]) begin
                        state_reg <= ST_PAUSE;
                    end else begin
                        buttons_play <= deb_level & PLAY_MASK;
                    end
                end
                ST_PAUSE: begin
                    if (press_reg[1]) begin
                        state_reg <= ST_START;
                    end else if (press_reg[3]) begin
                        state_reg    <= ST_PLAY;
                        buttons_play <= deb_level & PLAY_MASK;
                    end
                end
                ST_OVER: begin
                    timer_reg <= timer_reg + 1'b1;
                    // A late-arriving final score is still caught on any OVER cycle.
                    if (score > high_score) begin
                        high_score <= score;
                    end
                    // timer_reg is zero only on the entry cycle, where a press is ignored.
                    if (timer_reg == TIMER_LAST || (press_reg[3] && timer_reg != '0)) begin
                        state_reg  <= ST_START;
                        new_record <= 1'b0;
                    end else if (score > high_score) begin
                        new_record <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= ST_START;
                end
            endcase
        end
    end

    assign game_state = state_reg;

endmodule
